// File: rtl/hub75_scan_if.sv
// Framebuffer read port of the HUB75 scanner.
// rd_data answers a read exactly one cycle after rd_en.
interface hub75_scan_if #(
    parameter int COLS   = 64,
    parameter int ADDR_W = 5,
    parameter int BITS   = 4
);
    localparam int CW = $clog2(COLS);

    logic              rd_en;
    logic [ADDR_W-1:0] rd_row;
    logic [CW-1:0]     rd_col;
    logic [6*BITS-1:0] rd_data;

    modport master (
        output rd_en,
        output rd_row,
        output rd_col,
        input  rd_data
    );

    modport slave (
        input  rd_en,
        input  rd_row,
        input  rd_col,
        output rd_data
    );
endinterface

// File: rtl/hub75_scan.sv
// HUB75 LED panel scanner: BCM bit-plane shift, latch and display timing
// with one framebuffer read per column slot.
module hub75_scan #(
    parameter int COLS     = 64,
    parameter int ADDR_W   = 5,
    parameter int BITS     = 4,
    parameter int BASE_T   = 8,
    parameter int CLK_HIGH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    hub75_scan_if.master      fb,
    output logic              r0,
    output logic              g0,
    output logic              b0,
    output logic              r1,
    output logic              g1,
    output logic              b1,
    output logic [ADDR_W-1:0] addr,
    output logic              clk_out,
    output logic              latch,
    output logic              oe,
    output logic              frame_done
);
    localparam int CW   = $clog2(COLS);
    localparam int PW   = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int SLOT = 3 + CLK_HIGH;
    localparam int SW   = $clog2(SLOT);
    localparam int DMAX = BASE_T << (BITS - 1);
    localparam int DW   = $clog2(DMAX + 1);

    localparam logic [CW-1:0]     COL_LAST = CW'(COLS - 1);
    localparam logic [PW-1:0]     PL_LAST  = PW'(BITS - 1);
    localparam logic [SW-1:0]     PH_LAST  = SW'(SLOT - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = '1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH,
        DISPLAY
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [PW-1:0]     plane_q, plane_d;
    logic [CW-1:0]     col_q, col_d;
    logic [SW-1:0]     ph_q, ph_d;
    logic [DW-1:0]     dcnt_q, dcnt_d;
    logic [5:0]        pix_q, pix_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              fd_q, fd_d;
    logic [BITS-1:0]   fld [6];

    wire slot_end = (ph_q == PH_LAST);
    wire col_end  = (col_q == COL_LAST);
    wire disp_end = (dcnt_q == '0);

    always_comb begin
        for (int k = 0; k < 6; k++) begin
            fld[k] = fb.rd_data[k*BITS +: BITS];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            plane_q <= '0;
            col_q   <= '0;
            ph_q    <= '0;
            dcnt_q  <= '0;
            pix_q   <= '0;
            addr_q  <= '0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            plane_q <= plane_d;
            col_q   <= col_d;
            ph_q    <= ph_d;
            dcnt_q  <= dcnt_d;
            pix_q   <= pix_d;
            addr_q  <= addr_d;
            fd_q    <= fd_d;
        end
    end

    // enable only matters once the last plane of a row has been shown
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable) state_d = SHIFT;
            end
            SHIFT: begin
                if (slot_end && col_end) state_d = LATCH;
            end
            LATCH: begin
                state_d = DISPLAY;
            end
            DISPLAY: begin
                if (disp_end) begin
                    if (plane_q != PL_LAST || enable) state_d = SHIFT;
                    else                              state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        row_d   = row_q;
        plane_d = plane_q;
        col_d   = col_q;
        ph_d    = ph_q;
        dcnt_d  = dcnt_q;
        pix_d   = pix_q;
        addr_d  = addr_q;
        fd_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                row_d   = '0;
                plane_d = '0;
                col_d   = '0;
                ph_d    = '0;
            end
            SHIFT: begin
                if (ph_q == SW'(1)) begin
                    for (int k = 0; k < 6; k++) begin
                        pix_d[k] = fld[k][plane_q];
                    end
                end
                if (slot_end) begin
                    ph_d  = '0;
                    col_d = col_end ? '0 : col_q + CW'(1);
                    if (col_end) addr_d = row_q;
                end else begin
                    ph_d = ph_q + SW'(1);
                end
            end
            LATCH: begin
                dcnt_d = (DW'(BASE_T) << plane_q) - DW'(1);
            end
            DISPLAY: begin
                if (!disp_end) begin
                    dcnt_d = dcnt_q - DW'(1);
                end else if (plane_q != PL_LAST) begin
                    plane_d = plane_q + PW'(1);
                end else begin
                    plane_d = '0;
                    row_d   = row_q + ADDR_W'(1);
                    fd_d    = (row_q == ROW_LAST);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        fb.rd_en   = (state_q == SHIFT) && (ph_q == '0);
        fb.rd_row  = row_q;
        fb.rd_col  = col_q;
        clk_out    = (state_q == SHIFT) && (ph_q >= SW'(3));
        latch      = (state_q == LATCH);
        oe         = (state_q != DISPLAY);
        addr       = addr_q;
        frame_done = fd_q;
        {b1, g1, r1, b0, g0, r0} = pix_q;
    end
endmodule

// File: tb/tb_hub75_scan.sv
// Scoreboard bench for hub75_scan with a small panel and a
// one-cycle-latency framebuffer model.
module tb_hub75_scan;
    localparam int COLS     = 4;
    localparam int ADDR_W   = 2;
    localparam int BITS     = 2;
    localparam int BASE_T   = 2;
    localparam int CLK_HIGH = 1;
    localparam int ROWS     = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              r0, g0, b0, r1, g1, b1;
    logic [ADDR_W-1:0] addr;
    logic              clk_out, latch, oe, frame_done;

    hub75_scan_if #(.COLS(COLS), .ADDR_W(ADDR_W), .BITS(BITS)) fb ();

    hub75_scan #(
        .COLS(COLS), .ADDR_W(ADDR_W), .BITS(BITS),
        .BASE_T(BASE_T), .CLK_HIGH(CLK_HIGH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fb(fb),
        .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
        .addr(addr), .clk_out(clk_out), .latch(latch), .oe(oe),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int mode   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pat(input int m, input int col);
        if (m == 1) return 12'b10_10_10_01_01_01;
        return (col % 2 == 1) ? 12'h000 : 12'hFFF;
    endfunction

    // expected {b1,g1,r1,b0,g0,r0}, written out per pattern
    function automatic logic [5:0] exp_pix(input int m, input int col,
                                           input int pl);
        if (m == 1) return (pl == 0) ? 6'b000111 : 6'b111000;
        return (col % 2 == 1) ? 6'h00 : 6'h3F;
    endfunction

    always @(posedge clk) begin
        fb.rd_data <= fb.rd_en ? pat(mode, int'(fb.rd_col)) : '0;
    end

    logic [5:0] q[$];
    int  m_row, m_plane, m_col;
    int  cyc = 0, shift_start, last_latch, last_pl, frame_start;
    int  rises, oe_len, lat_cnt = 0, fd_cnt = 0, rd_cnt = 0;
    bit  prev_clk, prev_oe = 1'b1, prev_fd;
    wire [5:0] pix = {b1, g1, r1, b0, g0, r0};

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
            m_row = 0; m_plane = 0; m_col = 0;
            rises = 0; oe_len = 0; last_latch = -1;
            prev_clk = 1'b0; prev_oe = 1'b1; prev_fd = 1'b0;
        end else begin
            if (oe && !prev_oe) begin
                chk("oe_len", oe_len, BASE_T << m_plane);
                oe_len = 0;
                if (m_plane == BITS - 1) begin
                    m_plane = 0;
                    m_row = (m_row + 1) % ROWS;
                end else begin
                    m_plane++;
                end
            end
            if (frame_done) begin
                fd_cnt++;
                chk("frame_len", cyc - frame_start, 160);
                chk("frame_wrap", m_row * 8 + m_plane, 0);
                chk("fd_width", prev_fd, 0);
            end
            if (fb.rd_en) begin
                rd_cnt++;
                chk("rd_row", fb.rd_row, m_row);
                chk("rd_col", fb.rd_col, m_col);
                if (m_col == 0) shift_start = cyc;
                if (m_col == 0 && m_row == 0 && m_plane == 0)
                    frame_start = cyc;
                q.push_back(exp_pix(mode, m_col, m_plane));
                m_col = (m_col + 1) % COLS;
            end
            if (clk_out && !prev_clk) begin
                rises++;
                if (q.size() == 0) chk("q_underflow", 1, 0);
                else               chk("pixel", pix, q.pop_front());
            end
            if (latch) begin
                lat_cnt++;
                chk("latch_addr", addr, m_row);
                chk("rises", rises, COLS);
                chk("shift_len", cyc - shift_start, 16);
                if (last_latch >= 0)
                    chk("plane_period", cyc - last_latch,
                        (last_pl == 0) ? 19 : 21);
                last_latch = cyc;
                last_pl = m_plane;
                rises = 0;
            end
            if (!oe) oe_len++;
            prev_clk = clk_out;
            prev_oe = oe;
            prev_fd = frame_done;
        end
    end

    initial begin
        int snap_lat, snap_rd;
        bit found;
        rst_n = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_oe", oe, 1);
        chk("rst_ctl", {clk_out, latch, fb.rd_en, frame_done, addr}, 0);
        chk("rst_pix", pix, 0);
        enable = 1'b1;
        rst_n = 1'b1;

        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (fd_cnt >= 1) begin found = 1'b1; break; end
        end
        chk("fd_seen", found, 1);

        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (latch && addr == 2) begin found = 1'b1; break; end
        end
        chk("latch2_seen", found, 1);
        @(negedge clk);
        chk("disp_oe", oe, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_oe", oe, 1);
        chk("arst_ctl", {latch, clk_out, fb.rd_en, addr}, 0);
        snap_lat = lat_cnt;
        repeat (3) @(negedge clk);
        chk("arst_nolatch", lat_cnt, snap_lat);
        mode = 1;
        rst_n = 1'b1;

        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (fb.rd_en && fb.rd_row == 1) begin found = 1'b1; break; end
        end
        chk("row1_seen", found, 1);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        snap_lat = lat_cnt;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (lat_cnt == snap_lat + 2) begin found = 1'b1; break; end
        end
        chk("row1_done", found, 1);
        repeat (10) @(negedge clk);
        snap_rd = rd_cnt;
        repeat (60) @(negedge clk);
        chk("idle_rd", rd_cnt, snap_rd);
        chk("idle_lat", lat_cnt, snap_lat + 2);
        chk("idle_oe", oe, 1);
        chk("idle_clk", clk_out, 0);
        chk("idle_row", m_row, 2);
        chk("q_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hub75_scan.md
HUB75_SCAN -- requirements
Module: hub75_scan

Interface
REQ-001 SHALL provide parameter COLS, default 64, panel columns per shift (>=2).
REQ-002 SHALL provide parameter ADDR_W, default 5, row-address width; scanned rows = 2^ADDR_W.
REQ-003 SHALL provide parameter BITS, default 4, colour bit depth per channel (>=1).
REQ-004 SHALL provide parameter BASE_T, default 8, display cycles for bit plane 0 (>=1).
REQ-005 SHALL provide parameter CLK_HIGH, default 1, cycles clk_out is held high per column (>=1).
REQ-006 SHALL have ports: clk input 1 system clock; rst_n input 1 reset.
REQ-007 SHALL have port enable, input, 1 bit, scan run request.
REQ-008 SHALL have ports rd_en output 1, rd_row output ADDR_W, rd_col output clog2(COLS): framebuffer read request.
REQ-009 SHALL have port rd_data, input, 6*BITS bits, packed {b1,g1,r1,b0,g0,r0} with each field BITS wide, valid exactly 1 cycle after rd_en.
REQ-010 SHALL have ports r0,g0,b0,r1,g1,b1, outputs, 1 bit each, panel data.
REQ-011 SHALL have ports addr output ADDR_W, clk_out output 1, latch output 1, oe output 1 (active-low panel enable).
REQ-012 SHALL have port frame_done, output, 1 bit, one-cycle pulse at frame end.
REQ-013 Clock: single clock clk, all state on its rising edge; reset rst_n asynchronous, active-low.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT, LATCH, DISPLAY.
REQ-015 IDLE: oe=1, clk_out=0, rd_en=0; enable=1 SHALL enter SHIFT with row=0, plane=0, col=0.
REQ-016 SHIFT column slot SHALL be 3+CLK_HIGH cycles: cycle0 rd_en=1, rd_row=row, rd_col=col; cycle1 outputs r0..b1 load rd_data bit [plane] of each field; cycle2 clk_out=0, data stable; cycles 3..2+CLK_HIGH clk_out=1.
REQ-017 r0=rd_data[plane], g0=rd_data[BITS+plane], b0=[2*BITS+plane], r1=[3*BITS+plane], g1=[4*BITS+plane], b1=[5*BITS+plane].
REQ-018 Data outputs SHALL not change while clk_out=1; oe SHALL stay 1 throughout SHIFT and LATCH.
REQ-019 After column COLS-1's last clk_out-high cycle, SHALL enter LATCH for exactly 1 cycle: latch=1, clk_out=0, addr<=row in that cycle.
REQ-020 DISPLAY SHALL hold oe=0 for exactly BASE_T<<plane cycles, latch=0, addr stable.
REQ-021 Cycles per plane SHALL equal COLS*(3+CLK_HIGH)+1+(BASE_T<<plane), no gaps.
REQ-022 After DISPLAY: plane<BITS-1 -> plane+1, SHIFT same row; else plane=0, row+1.
REQ-023 Row wrap: after row 2^ADDR_W-1 plane BITS-1, row SHALL wrap to 0 and frame_done SHALL pulse 1 cycle, coincident with first cycle of next SHIFT or IDLE.
REQ-024 enable SHALL be sampled only at end of each row's last DISPLAY; enable=0 there -> IDLE, oe=1; deassertion mid-row SHALL NOT truncate the row.
REQ-025 Counters SHALL use exact widths; col wraps at COLS-1 (non-power-of-two COLS legal), display counter wide enough for BASE_T<<(BITS-1).
REQ-026 rd_en SHALL be 1 only in slot cycle0; at most one read outstanding.

Reset
REQ-027 rst_n=0 SHALL immediately force: state IDLE, row/plane/col 0, r0..b1=0, addr=0, clk_out=0, latch=0, oe=1, rd_en=0, frame_done=0.
REQ-028 Reset mid-SHIFT or mid-DISPLAY SHALL abort with no further latch pulse; restart from row 0, plane 0 after release if enable=1.

Verification (COLS=4, ADDR_W=2, BITS=2, BASE_T=2, CLK_HIGH=1)
REQ-029 Assert rst_n=0 mid-DISPLAY -> same cycle oe=1, latch=0, clk_out=0, addr=0, rd_en=0.
REQ-030 enable=1, rd_data col c = 12'hFFF for c even, 0 odd -> 4 clk_out rising edges per plane, sampled r0..b1 = 1,0,1,0, 16 SHIFT cycles then one latch.
REQ-031 Plane timing -> oe low exactly 2 cycles (plane 0), 4 cycles (plane 1); plane periods 19 and 21 cycles.
REQ-032 Full frame -> addr sequence 0,1,2,3 at latches, frame_done one pulse after 160 cycles, then row 0 again.
REQ-033 Drop enable during row 1 plane 0 SHIFT -> row 1 completes both planes, then IDLE, oe=1, no further rd_en.
REQ-034 rd_data=12'b10_10_10_01_01_01 -> plane 0 r0,g0,b0=1, r1,g1,b1=0; plane 1 inverted.
